// File: rtl/intersection_ctrl.sv
// Two-approach (NS/EW) traffic-light controller: timed greens, yellows and all-red clearance,
// with an optional pedestrian walk phase enabled by defining INTERSECTION_PED_EN.
module intersection_ctrl #(
  parameter int TW       = 8,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 10,
  parameter int T_ALLRED = 5,
  parameter int T_WALK   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       walk,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_NS_G  = 3'd1,
    S_NS_Y  = 3'd2,
    S_AR_NS = 3'd3,
    S_EW_G  = 3'd4,
    S_EW_Y  = 3'd5,
    S_AR_EW = 3'd6,
    S_WALK  = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_dur;
  logic            w_expire;
  logic            w_ped;

`ifdef INTERSECTION_PED_EN
  logic r_ped_pending;
  // A request arriving in the same cycle AR_EW expires still counts.
  assign w_ped = r_ped_pending | ped_req;
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_req;
  assign w_ped        = 1'b0;
`endif

  always_comb begin
    w_dur = TW'(1);
    case (r_state)
      S_NS_G, S_EW_G:   w_dur = TW'(T_GREEN);
      S_NS_Y, S_EW_Y:   w_dur = TW'(T_YELLOW);
      S_AR_NS, S_AR_EW: w_dur = TW'(T_ALLRED);
      S_WALK:           w_dur = TW'(T_WALK);
      default:          w_dur = TW'(1);
    endcase
  end

  assign w_expire = (r_timer == (w_dur - TW'(1)));

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:   w_next = S_AR_EW;
        S_NS_G:  if (w_expire) w_next = S_NS_Y;
        S_NS_Y:  if (w_expire) w_next = S_AR_NS;
        S_AR_NS: if (w_expire) w_next = S_EW_G;
        S_EW_G:  if (w_expire) w_next = S_EW_Y;
        S_EW_Y:  if (w_expire) w_next = S_AR_EW;
        S_AR_EW: if (w_expire) w_next = w_ped ? S_WALK : S_NS_G;
`ifdef INTERSECTION_PED_EN
        S_WALK:  if (w_expire) w_next = S_NS_G;
`endif
        default: w_next = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OFF;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      // Timer restarts on any state change and stays at zero while OFF.
      if ((w_next != r_state) || (r_state == S_OFF))
        r_timer <= '0;
      else
        r_timer <= r_timer + TW'(1);
    end
  end

`ifdef INTERSECTION_PED_EN
  always_ff @(posedge clk) begin
    if (reset || !enable)
      r_ped_pending <= 1'b0;
    else if ((w_next == S_WALK) && (r_state != S_WALK))
      r_ped_pending <= 1'b0;
    else if (ped_req && (r_state != S_OFF) && (r_state != S_WALK))
      r_ped_pending <= 1'b1;
  end
`endif

  always_comb begin
    ns_lamp = 3'b100;
    ew_lamp = 3'b100;
    walk    = 1'b0;
    case (r_state)
      S_OFF:  begin ns_lamp = 3'b000; ew_lamp = 3'b000; end
      S_NS_G: ns_lamp = 3'b001;
      S_NS_Y: ns_lamp = 3'b010;
      S_EW_G: ew_lamp = 3'b001;
      S_EW_Y: ew_lamp = 3'b010;
      S_WALK: walk    = 1'b1;
      default: ;
    endcase
  end

  assign state_out = r_state;

endmodule
